// File: rtl/ctrl_evt_queue_pkg.sv
// Shared definitions for the control-event queue: FSM encodings and sim delay.
package ctrl_evt_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Simulation-only sampling offset used by benches around clock edges.
  localparam int unsigned TD = 1;

endpackage

// File: rtl/ctrl_edge_det.sv
// Rising-edge detector on a synchronized control level.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   ctrl_i      - synchronized control level
//   rise_c_o    - combinational rise indication (ctrl_i high, previous sample low)
//   pulse_o     - registered single-cycle pulse, one cycle after rise_c_o
module ctrl_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic ctrl_i,
  output logic rise_c_o,
  output logic pulse_o
);

  logic ctrl_q;

  assign rise_c_o = ctrl_i & ~ctrl_q;

  // Resetting ctrl_q high suppresses a level that is already high at reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= RST_VAL;
      pulse_o <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_i;
      pulse_o <= rise_c_o;
    end
  end

endmodule

// File: rtl/ctrl_evt_queue.sv
// Counts rising edges of a synchronized control level into a saturating
// pending counter and hands them one at a time to a consumer via req/ack.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   ctrl_sync_i  - synchronized control level
//   evt_pulse_o  - one-cycle pulse per detected rising edge
//   evt_req_o    - request to consumer; grant = evt_req_o & evt_ack_i
//   evt_ack_i    - consumer acknowledge
//   evt_pend_o   - pending, not-yet-granted event count
//   evt_ovf_o    - sticky flag: an event was dropped at saturation
//   ovf_clr_i    - synchronous clear of evt_ovf_o (a same-cycle set wins)
module ctrl_evt_queue
  import ctrl_evt_queue_pkg::*;
#(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned GAP_CYC = 0,
  parameter int unsigned GAP_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_sync_i,
  output logic             evt_pulse_o,
  output logic             evt_req_o,
  input  logic             evt_ack_i,
  output logic [CNT_W-1:0] evt_pend_o,
  output logic             evt_ovf_o,
  input  logic             ovf_clr_i
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ovf_q, ovf_d;
  logic             rise_c;
  logic             grant_c;

  ctrl_edge_det #(
    .RST_VAL (1'b1)
  ) u_edge (
    .clk      (clk),
    .rst      (rst),
    .ctrl_i   (ctrl_sync_i),
    .rise_c_o (rise_c),
    .pulse_o  (evt_pulse_o)
  );

  // Ack outside REQ never counts as a grant.
  assign grant_c = (state_q == ST_REQ) & evt_ack_i;

  // Next-state: pending counter, overflow flag and request FSM.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    gap_d   = gap_q;
    ovf_d   = ovf_q;

    if (ovf_clr_i) ovf_d = 1'b0;

    unique case ({rise_c, grant_c})
      2'b10: begin
        if (pend_q != PEND_MAX) pend_d = pend_q + CNT_W'(1);
        else                    ovf_d  = 1'b1;
      end
      2'b01:   pend_d = pend_q - CNT_W'(1);
      default: pend_d = pend_q;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q != '0) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (grant_c) begin
          if (GAP_CYC != 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else if (pend_d != '0) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      gap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_req_o  = (state_q == ST_REQ);
  assign evt_pend_o = pend_q;
  assign evt_ovf_o  = ovf_q;

endmodule

// File: tb/tb_ctrl_evt_queue.sv
// Directed bench: instance a (defaults), b (GAP_CYC=2), c (CNT_W=2).
module tb_ctrl_evt_queue;
  import ctrl_evt_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic ctrl_a = 1'b1, ack_a = 1'b0, clr_a = 1'b0;
  logic pulse_a, req_a, ovf_a;
  logic [3:0] pend_a;

  logic ctrl_b = 1'b0, ack_b = 1'b0, clr_b = 1'b0;
  logic pulse_b, req_b, ovf_b;
  logic [3:0] pend_b;

  logic ctrl_c = 1'b0, ack_c = 1'b0, clr_c = 1'b0;
  logic pulse_c, req_c, ovf_c;
  logic [1:0] pend_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_evt_queue u_a (
    .clk(clk), .rst(rst), .ctrl_sync_i(ctrl_a), .evt_pulse_o(pulse_a),
    .evt_req_o(req_a), .evt_ack_i(ack_a), .evt_pend_o(pend_a),
    .evt_ovf_o(ovf_a), .ovf_clr_i(clr_a)
  );

  ctrl_evt_queue #(.CNT_W(4), .GAP_CYC(2), .GAP_W(8)) u_b (
    .clk(clk), .rst(rst), .ctrl_sync_i(ctrl_b), .evt_pulse_o(pulse_b),
    .evt_req_o(req_b), .evt_ack_i(ack_b), .evt_pend_o(pend_b),
    .evt_ovf_o(ovf_b), .ovf_clr_i(clr_b)
  );

  ctrl_evt_queue #(.CNT_W(2), .GAP_CYC(0), .GAP_W(8)) u_c (
    .clk(clk), .rst(rst), .ctrl_sync_i(ctrl_c), .evt_pulse_o(pulse_c),
    .evt_req_o(req_c), .evt_ack_i(ack_c), .evt_pend_o(pend_c),
    .evt_ovf_o(ovf_c), .ovf_clr_i(clr_c)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled TD after the edge.
  task automatic step();
    @(posedge clk);
    #TD;
  endtask

  initial begin
    // Reset values on all instances.
    step();
    chk("rst_pulse_a", {7'd0, pulse_a}, 8'd0);
    chk("rst_req_a",   {7'd0, req_a},   8'd0);
    chk("rst_pend_a",  {4'd0, pend_a},  8'd0);
    chk("rst_ovf_a",   {7'd0, ovf_a},   8'd0);
    chk("rst_req_b",   {7'd0, req_b},   8'd0);
    chk("rst_pend_c",  {6'd0, pend_c},  8'd0);

    // Level already high at reset release is not an event.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hi_at_rel_pulse", {7'd0, pulse_a}, 8'd0);
    end
    chk("hi_at_rel_pend", {4'd0, pend_a}, 8'd0);
    chk("hi_at_rel_req",  {7'd0, req_a},  8'd0);

    // Single edge, ack tied high: pulse cycle 1, req only cycle 2, pend 0,1,1,0.
    ctrl_a = 1'b0; ack_a = 1'b1;
    step();
    chk("t2_pend0", {4'd0, pend_a}, 8'd0);
    ctrl_a = 1'b1;
    step();
    chk("t2_c1_pulse", {7'd0, pulse_a}, 8'd1);
    chk("t2_c1_pend",  {4'd0, pend_a},  8'd1);
    chk("t2_c1_req",   {7'd0, req_a},   8'd0);
    step();
    chk("t2_c2_pulse", {7'd0, pulse_a}, 8'd0);
    chk("t2_c2_pend",  {4'd0, pend_a},  8'd1);
    chk("t2_c2_req",   {7'd0, req_a},   8'd1);
    step();
    chk("t2_c3_pend",  {4'd0, pend_a},  8'd0);
    chk("t2_c3_req",   {7'd0, req_a},   8'd0);
    step();
    chk("t2_c4_req",   {7'd0, req_a},   8'd0);
    chk("t2_c4_pulse", {7'd0, pulse_a}, 8'd0);
    ctrl_a = 1'b0; ack_a = 1'b0;
    step();

    // Three separated edges with ack low, then back-to-back grants.
    for (int e = 1; e <= 3; e++) begin
      ctrl_a = 1'b1;
      step();
      chk("t3_inc_pend", {4'd0, pend_a}, 8'(e));
      ctrl_a = 1'b0;
      step();
    end
    chk("t3_pend3", {4'd0, pend_a}, 8'd3);
    chk("t3_req",   {7'd0, req_a},  8'd1);
    ack_a = 1'b1;
    step();
    chk("t3_g1_pend", {4'd0, pend_a}, 8'd2);
    chk("t3_g1_req",  {7'd0, req_a},  8'd1);
    step();
    chk("t3_g2_pend", {4'd0, pend_a}, 8'd1);
    chk("t3_g2_req",  {7'd0, req_a},  8'd1);
    step();
    chk("t3_g3_pend", {4'd0, pend_a}, 8'd0);
    chk("t3_g3_req",  {7'd0, req_a},  8'd0);
    ack_a = 1'b0;

    // GAP_CYC=2: two pending, ack high -> req 1 high, 3 low, 1 high.
    for (int e = 0; e < 2; e++) begin
      ctrl_b = 1'b1; step();
      ctrl_b = 1'b0; step();
    end
    chk("t4_pend2", {4'd0, pend_b}, 8'd2);
    chk("t4_req",   {7'd0, req_b},  8'd1);
    ack_b = 1'b1;
    step();
    chk("t4_gap1_req",  {7'd0, req_b},  8'd0);
    chk("t4_gap1_pend", {4'd0, pend_b}, 8'd1);
    step();
    chk("t4_gap2_req",  {7'd0, req_b},  8'd0);
    step();
    chk("t4_idle_req",  {7'd0, req_b},  8'd0);
    step();
    chk("t4_req2",      {7'd0, req_b},  8'd1);
    chk("t4_req2_pend", {4'd0, pend_b}, 8'd1);
    step();
    chk("t4_end_req",   {7'd0, req_b},  8'd0);
    chk("t4_end_pend",  {4'd0, pend_b}, 8'd0);
    ack_b = 1'b0;

    // CNT_W=2: saturation, overflow, clear, set-wins, simultaneous inc/dec.
    for (int e = 1; e <= 4; e++) begin
      ctrl_c = 1'b1; step();
      if (e == 3) chk("t5_ovf_before", {7'd0, ovf_c}, 8'd0);
      ctrl_c = 1'b0; step();
    end
    chk("t5_pend_sat", {6'd0, pend_c}, 8'd3);
    chk("t5_ovf_set",  {7'd0, ovf_c},  8'd1);
    clr_c = 1'b1;
    step();
    chk("t5_ovf_clr", {7'd0, ovf_c}, 8'd0);
    clr_c = 1'b1; ctrl_c = 1'b1;
    step();
    chk("t5_set_wins", {7'd0, ovf_c},  8'd1);
    chk("t5_sat_hold", {6'd0, pend_c}, 8'd3);
    ctrl_c = 1'b0;
    step();
    chk("t5_ovf_clr2", {7'd0, ovf_c}, 8'd0);
    clr_c = 1'b0;
    chk("t5_req_sat",  {7'd0, req_c}, 8'd1);
    ctrl_c = 1'b1; ack_c = 1'b1;
    step();
    chk("t5_incdec_pend", {6'd0, pend_c}, 8'd3);
    chk("t5_incdec_ovf",  {7'd0, ovf_c},  8'd0);
    ctrl_c = 1'b0; ack_c = 1'b0;
    step();
    chk("t5_after_pend", {6'd0, pend_c}, 8'd3);

    // Asynchronous reset while requesting with two pending.
    for (int e = 0; e < 2; e++) begin
      ctrl_a = 1'b1; step();
      ctrl_a = 1'b0; step();
    end
    chk("t6_pend2", {4'd0, pend_a}, 8'd2);
    chk("t6_req",   {7'd0, req_a},  8'd1);
    rst = 1'b1;
    #TD;
    chk("t6_async_req",  {7'd0, req_a},  8'd0);
    chk("t6_async_pend", {4'd0, pend_a}, 8'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_idle_req", {7'd0, req_a}, 8'd0);
    end
    chk("t6_idle_pend", {4'd0, pend_a}, 8'd0);
    ctrl_a = 1'b1;
    step();
    chk("t6_new_pend", {4'd0, pend_a}, 8'd1);
    step();
    chk("t6_new_req",  {7'd0, req_a},  8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
